// File: rtl/demux1to4_8bit_buf_pkg.sv
// Shared definitions for the 1-to-4 buffered demux: select encodings and default data width.
package demux1to4_8bit_buf_pkg;

  localparam int unsigned W = 8;

  localparam logic [1:0] SEL_I0 = 2'b00;
  localparam logic [1:0] SEL_I1 = 2'b01;
  localparam logic [1:0] SEL_I2 = 2'b10;
  localparam logic [1:0] SEL_I3 = 2'b11;

endpackage

// File: rtl/demux1to4_8bit_buf_if.sv
// Bus bundle for the buffered demux: input handshake, four output lanes and the accept counter.
interface demux1to4_8bit_buf_if #(
  parameter int unsigned W = 8
) ();

  logic         sel1;
  logic         sel0;
  logic [W-1:0] d;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] f0;
  logic [W-1:0] f1;
  logic [W-1:0] f2;
  logic [W-1:0] f3;
  logic         v0;
  logic         v1;
  logic         v2;
  logic         v3;
  logic         r0;
  logic         r1;
  logic         r2;
  logic         r3;
  logic [7:0]   acc_cnt;

  modport master (
    output sel1, sel0, d, in_valid, r0, r1, r2, r3,
    input  in_ready, f0, f1, f2, f3, v0, v1, v2, v3, acc_cnt
  );

  modport slave (
    input  sel1, sel0, d, in_valid, r0, r1, r2, r3,
    output in_ready, f0, f1, f2, f3, v0, v1, v2, v3, acc_cnt
  );

endinterface

// File: rtl/demux_slot.sv
// One output lane: a W-bit data register with a full flag and its valid/ready handshake.
module demux_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hit,
  input  logic         in_valid,
  input  logic [W-1:0] d,
  input  logic         r,
  output logic [W-1:0] f,
  output logic         v,
  output logic         ready
);

  logic [W-1:0] data_q;
  logic         full_q;
  logic         load;

  // A draining lane can take new data in the same cycle, so there is no bubble.
  assign ready = ~full_q | r;
  assign load  = hit & in_valid & ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (load) begin
      data_q <= d;
      full_q <= 1'b1;
    end else if (full_q && r) begin
      full_q <= 1'b0;
    end
  end

  assign f = data_q;
  assign v = full_q;

endmodule

// File: rtl/demux1to4_8bit_buf.sv
// 1-to-4 demux with a one-entry buffer per lane and a count of accepted input transfers.
module demux1to4_8bit_buf
  import demux1to4_8bit_buf_pkg::*;
#(
  parameter int unsigned W = demux1to4_8bit_buf_pkg::W
) (
  input logic                  clk,
  input logic                  rst_n,
  demux1to4_8bit_buf_if.slave  bus
);

  logic [1:0] sel;
  logic [3:0] hit;
  logic [3:0] rdy;
  logic [7:0] cnt_q;

  assign sel = {bus.sel1, bus.sel0};

  always_comb begin
    hit = 4'b0000;
    unique case (sel)
      SEL_I0: hit = 4'b0001;
      SEL_I1: hit = 4'b0010;
      SEL_I2: hit = 4'b0100;
      SEL_I3: hit = 4'b1000;
      default: hit = 4'b0000;
    endcase
  end

  demux_slot #(.W(W)) u_slot0 (
    .clk(clk), .rst_n(rst_n), .hit(hit[0]), .in_valid(bus.in_valid), .d(bus.d),
    .r(bus.r0), .f(bus.f0), .v(bus.v0), .ready(rdy[0])
  );

  demux_slot #(.W(W)) u_slot1 (
    .clk(clk), .rst_n(rst_n), .hit(hit[1]), .in_valid(bus.in_valid), .d(bus.d),
    .r(bus.r1), .f(bus.f1), .v(bus.v1), .ready(rdy[1])
  );

  demux_slot #(.W(W)) u_slot2 (
    .clk(clk), .rst_n(rst_n), .hit(hit[2]), .in_valid(bus.in_valid), .d(bus.d),
    .r(bus.r2), .f(bus.f2), .v(bus.v2), .ready(rdy[2])
  );

  demux_slot #(.W(W)) u_slot3 (
    .clk(clk), .rst_n(rst_n), .hit(hit[3]), .in_valid(bus.in_valid), .d(bus.d),
    .r(bus.r3), .f(bus.f3), .v(bus.v3), .ready(rdy[3])
  );

  assign bus.in_ready = rdy[sel];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (bus.in_valid && bus.in_ready) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus.acc_cnt = cnt_q;

endmodule

// File: tb/tb_demux1to4_8bit_buf.sv
// Self-checking bench: directed scenarios plus random traffic against a lane-level reference model.
module tb_demux1to4_8bit_buf;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  demux1to4_8bit_buf_if #(.W(8)) bus ();

  demux1to4_8bit_buf #(.W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Reference model: per-lane stored byte and occupancy, plus a mod-256 transfer count.
  logic [7:0] m_f [4];
  bit         m_v [4];
  int         m_cnt;
  int         n_chk;
  int         n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_f(input int i);
    case (i)
      0:       return bus.f0;
      1:       return bus.f1;
      2:       return bus.f2;
      default: return bus.f3;
    endcase
  endfunction

  function automatic logic [3:0] dut_v();
    return {bus.v3, bus.v2, bus.v1, bus.v0};
  endfunction

  function automatic logic [3:0] cur_r();
    return {bus.r3, bus.r2, bus.r1, bus.r0};
  endfunction

  function automatic int cur_sel();
    return int'({bus.sel1, bus.sel0});
  endfunction

  function automatic bit model_ready();
    logic [3:0] r;
    r = cur_r();
    return !m_v[cur_sel()] || r[cur_sel()];
  endfunction

  task automatic drive(input int sel, input logic [7:0] dv, input bit val, input logic [3:0] r);
    bus.sel1     = sel[1];
    bus.sel0     = sel[0];
    bus.d        = dv;
    bus.in_valid = val;
    {bus.r3, bus.r2, bus.r1, bus.r0} = r;
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("f%0d", i), 32'(dut_f(i)), 32'(m_f[i]));
      chk($sformatf("v%0d", i), 32'(dut_v() >> i) & 32'd1, 32'(m_v[i]));
    end
    chk("acc_cnt", 32'(bus.acc_cnt), 32'(m_cnt));
  endtask

  // One clock: check in_ready for the current inputs, clock, advance the model, check outputs.
  task automatic cycle();
    bit         acc;
    int         s;
    logic [3:0] r;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(model_ready()));
    @(posedge clk);
    s   = cur_sel();
    r   = cur_r();
    acc = bus.in_valid && model_ready();
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_f[i] = 8'h00;
        m_v[i] = 1'b0;
      end
      m_cnt = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (acc && i == s) begin
          m_f[i] = bus.d;
          m_v[i] = 1'b1;
        end else if (m_v[i] && r[i]) begin
          m_v[i] = 1'b0;
        end
      end
      if (acc) m_cnt = (m_cnt + 1) % 256;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 8'h00, 1'b0, 4'h0);
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  logic [7:0] bytes [4];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    m_cnt  = 0;
    for (int i = 0; i < 4; i++) begin
      m_f[i] = 8'h00;
      m_v[i] = 1'b0;
    end
    bytes[0] = 8'b10100100;
    bytes[1] = 8'b00001111;
    bytes[2] = 8'b00011101;
    bytes[3] = 8'b10011100;

    do_reset();
    chk("lit_rst_v", 32'(dut_v()), 32'h0);
    chk("lit_rst_cnt", 32'(bus.acc_cnt), 32'h0);
    chk("lit_rst_ready", 32'(bus.in_ready), 32'h1);

    // First transfer into lane 0.
    drive(0, 8'b10100100, 1'b1, 4'h0);
    cycle();
    chk("lit_first_f0", 32'(bus.f0), 32'hA4);
    chk("lit_first_v", 32'(dut_v()), 32'b0001);
    chk("lit_first_cnt", 32'(bus.acc_cnt), 32'h1);

    // Lane 0 full and stalled; redirect to lane 1.
    drive(0, 8'b00001111, 1'b1, 4'h0);
    #1;
    chk("lit_stall_ready", 32'(bus.in_ready), 32'h0);
    cycle();
    chk("lit_stall_f0", 32'(bus.f0), 32'hA4);
    drive(1, 8'b00001111, 1'b1, 4'h0);
    #1;
    chk("lit_redirect_ready", 32'(bus.in_ready), 32'h1);
    cycle();
    chk("lit_redirect_f1", 32'(bus.f1), 32'h0F);

    // Simultaneous drain and refill of lane 2.
    drive(2, 8'b00011101, 1'b1, 4'h0);
    cycle();
    drive(2, 8'b10011100, 1'b1, 4'b0100);
    cycle();
    chk("lit_refill_v2", 32'(bus.v2), 32'h1);
    chk("lit_refill_f2", 32'(bus.f2), 32'h9C);

    // Fill all four lanes then drain them together.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(i, bytes[i], 1'b1, 4'h0);
      cycle();
    end
    drive(0, 8'h00, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("lit_fill_f%0d", i), 32'(dut_f(i)), 32'(bytes[i]));
    chk("lit_fill_v", 32'(dut_v()), 32'hF);
    drive(0, 8'h00, 1'b0, 4'hF);
    cycle();
    chk("lit_drain_v", 32'(dut_v()), 32'h0);

    // 256 accepted transfers wrap the counter; all lanes always draining so each is accepted.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(int'($urandom_range(0, 3)), 8'($urandom), 1'b1, 4'hF);
      cycle();
    end
    chk("lit_wrap_cnt", 32'(bus.acc_cnt), 32'h0);

    // Reset with full lanes discards everything, including a coincident transfer.
    for (int i = 0; i < 4; i++) begin
      drive(i, bytes[i], 1'b1, 4'h0);
      cycle();
    end
    rst_n = 1'b0;
    drive(0, 8'h55, 1'b1, 4'h0);
    cycle();
    chk("lit_midrst_v", 32'(dut_v()), 32'h0);
    chk("lit_midrst_f0", 32'(bus.f0), 32'h0);
    chk("lit_midrst_f3", 32'(bus.f3), 32'h0);
    chk("lit_midrst_cnt", 32'(bus.acc_cnt), 32'h0);
    rst_n = 1'b1;

    // Random traffic with sparse draining and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 99) < 35);
      rst_n = ($urandom_range(0, 199) != 0);
      drive(int'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 99) < 70), r);
      cycle();
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1to4_8bit_buf.md
DEMUX1TO4_8BIT_BUF -- requirements
Module: demux1to4_8bit_buf

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the data width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset; it is synchronous and active-low.
REQ-004 The block SHALL have ports sel1 and sel0, inputs, 1 each, the destination select; {sel1,sel0}=00/01/10/11 selects f0/f1/f2/f3.
REQ-005 The block SHALL have port d, input, W, the input data.
REQ-006 The block SHALL have port in_valid, input, 1, meaning d and select are valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts d this cycle.
REQ-008 The block SHALL have ports f0, f1, f2, f3, outputs, W each, the lane output data.
REQ-009 The block SHALL have ports v0, v1, v2, v3, outputs, 1 each, meaning the lane holds valid data.
REQ-010 The block SHALL have ports r0, r1, r2, r3, inputs, 1 each, meaning the lane consumer takes data this cycle.
REQ-011 The block SHALL have port acc_cnt, output, 8, the count of accepted input transfers.

Function
REQ-012 Each lane n SHALL hold one W-bit register and one full flag; vn equals the full flag and fn equals the register.
REQ-013 Input handshake: a transfer SHALL occur when in_valid and in_ready are both 1 at a rising clk edge.
REQ-014 in_ready SHALL equal (not full of the selected lane) OR (rn of the selected lane); it is combinational from the select and r inputs, and independent of in_valid.
REQ-015 Latency: d accepted at edge k SHALL appear on the selected fn with vn=1 from edge k onward, i.e. one cycle of latency; there is no combinational path from d to fn.
REQ-016 Output handshake: the lane SHALL drain when vn=1 and rn=1 at an edge; rn while vn=0 SHALL have no effect.
REQ-017 Simultaneous drain and fill of the same lane SHALL load the new data and keep vn=1 without a bubble.
REQ-018 A full lane with rn=0 SHALL hold fn stable, and in_ready SHALL be 0 while that lane is selected; other lanes are unaffected.
REQ-019 Unselected lanes SHALL never load, regardless of in_valid.
REQ-020 Data, select and valid SHALL be sampled only at the transfer edge; select changes while in_ready=0 are permitted and re-evaluate in_ready.
REQ-021 acc_cnt SHALL increment by 1 per accepted transfer and wrap from 255 to 0.
REQ-022 All lanes SHALL be independent: any subset of the four may drain in the same cycle.

Reset
REQ-023 While rst_n=0 at an edge, v0..v3 SHALL go to 0, f0..f3 to 0, and acc_cnt to 0.
REQ-024 Reset asserted mid-operation SHALL discard held data, and a transfer coinciding with reset SHALL be dropped.
REQ-025 in_ready SHALL be 1 in the first cycle after reset because all lanes are empty.

Structure
REQ-026 A shared package SHALL hold the select encodings SEL_I0..SEL_I3 (2'b00..2'b11) and the default width W=8.
REQ-027 One sub-module demux_slot SHALL contain one lane's register, full flag and handshake; the top SHALL instantiate it four times, plus the select decode, in_ready mux and acc_cnt.

Verification
REQ-028 Scenario: after reset, sel=00, d=8'b10100100, in_valid=1, r0=0 -> next cycle v0=1, f0=8'b10100100, v1..v3=0, acc_cnt=1.
REQ-029 Scenario: lane 0 full with r0=0, sel=00, d=8'b00001111 -> in_ready=0, f0 unchanged; then sel=01 -> in_ready=1, f1=8'b00001111 next cycle.
REQ-030 Scenario: lane 2 full with 8'b00011101, r2=1 and a new transfer of sel=10, d=8'b10011100 -> v2 stays 1, f2=8'b10011100, no idle cycle.
REQ-031 Scenario: all four lanes filled with 8'b10100100, 8'b00001111, 8'b00011101, 8'b10011100, then r0..r3=1 together -> all v=0 next cycle, and each fn showed its own byte before the drain.
REQ-032 Scenario: 256 accepted transfers -> acc_cnt wraps to 0; rst_n=0 with lanes full -> all v=0, f=0, acc_cnt=0 next cycle.
